// File: rtl/tt_serial_pkg.sv
// Shared defaults and types for the serial byte receiver.
package tt_serial_pkg;
    localparam int WIDTH       = 8;
    localparam int DEPTH       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int PTR_W       = $clog2(DEPTH);
    localparam int CNT_W       = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} rx_state_t;
endpackage

// File: rtl/tt_serial_byte_rx_if.sv
// Serial input wires plus FIFO read side of the receiver.
interface tt_serial_byte_rx_if #(parameter int WIDTH = tt_serial_pkg::WIDTH);
    logic             sdata_i;
    logic             sclk_i;
    logic             cs_n_i;
    logic             rd_i;
    logic [WIDTH-1:0] rdata_o;
    logic             rvalid_o;
    logic             full_o;
    logic             ovf_o;

    modport master (output sdata_i, sclk_i, cs_n_i, rd_i,
                    input  rdata_o, rvalid_o, full_o, ovf_o);
    modport slave  (input  sdata_i, sclk_i, cs_n_i, rd_i,
                    output rdata_o, rvalid_o, full_o, ovf_o);
endinterface

// File: rtl/tt_sync_fifo.sv
// DEPTH x WIDTH first-word-fall-through FIFO with sticky overflow flag.
module tt_sync_fifo #(
    parameter int WIDTH = tt_serial_pkg::WIDTH,
    parameter int DEPTH = tt_serial_pkg::DEPTH,
    parameter int PTR_W = tt_serial_pkg::PTR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic             ovf
);
    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PTR_W-1:0]            wptr, rptr;
    logic [PTR_W:0]              count;
    logic                        push_ok, pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign pop_ok  = pop & ~empty;
    // A pop frees the slot in the same edge, so a full FIFO still accepts a write
    assign push_ok = push & (~full | pop_ok);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + PTR_W'(1);
            end
            if (pop_ok)
                rptr <= rptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
            if (push && !push_ok)
                ovf <= 1'b1;
        end
    end
endmodule

// File: rtl/tt_serial_byte_rx.sv
// Synchronizes an async strobe/data/frame stream, deserializes MSB-first
// into words and buffers them in a small FWFT FIFO.
module tt_serial_byte_rx #(
    parameter int WIDTH       = tt_serial_pkg::WIDTH,
    parameter int DEPTH       = tt_serial_pkg::DEPTH,
    parameter int SYNC_STAGES = tt_serial_pkg::SYNC_STAGES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    tt_serial_byte_rx_if.slave  bus
);
    import tt_serial_pkg::*;

    localparam int CW = $clog2(WIDTH);
    localparam int PW = $clog2(DEPTH);

    logic [SYNC_STAGES-1:0] sdata_sync, sclk_sync, cs_n_sync;
    logic                   sclk_dly;
    logic                   sdata_s, sclk_s, cs_n_s, sclk_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdata_sync <= '0;
            sclk_sync  <= '0;
            cs_n_sync  <= '1;
            sclk_dly   <= 1'b0;
        end else begin
            sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], bus.sdata_i};
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk_i};
            cs_n_sync  <= {cs_n_sync[SYNC_STAGES-2:0], bus.cs_n_i};
            sclk_dly   <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign sdata_s   = sdata_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_n_s    = cs_n_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_dly;

    rx_state_t        state;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d, word;
    logic             push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    // Mode is decoded straight from the synced frame select so a deasserted
    // frame clears the counter without an additional register stage.
    always_comb begin
        state   = (!cs_n_s && ena) ? SHIFT : IDLE;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        push    = 1'b0;
        word    = {shreg_q[WIDTH-2:0], sdata_s};
        case (state)
            IDLE: cnt_d = '0;
            SHIFT: begin
                if (sclk_rise) begin
                    shreg_d = word;
                    if (cnt_q == CW'(WIDTH-1)) begin
                        cnt_d = '0;
                        push  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: cnt_d = '0;
        endcase
    end

    logic empty;

    tt_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (word),
        .pop   (bus.rd_i),
        .rdata (bus.rdata_o),
        .empty (empty),
        .full  (bus.full_o),
        .ovf   (bus.ovf_o)
    );

    assign bus.rvalid_o = ~empty;
endmodule

// File: tb/tb_tt_serial_byte_rx.sv
// Directed bench for tt_serial_byte_rx with a scoreboard of expected bytes
// checked by a monitor on every accepted pop.
module tb_tt_serial_byte_rx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b1;

    always #5 clk = ~clk;

    tt_serial_byte_rx_if #(.WIDTH(8)) bus();

    tt_serial_byte_rx #(.WIDTH(8), .DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle the DUT accepts a pop, its head must match the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus.rd_i && bus.rvalid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got 0x%0h, expected no data at %0t", bus.rdata_o, $time);
            end else begin
                check("pop_data", {24'h0, bus.rdata_o}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        bus.sdata_i = b;
        bus.sclk_i  = 1'b0;
        wait_clk(8);
        bus.sclk_i  = 1'b1;
        wait_clk(8);
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) drive_bit(v[7-i]);
    endtask

    task automatic open_frame();
        bus.cs_n_i = 1'b0;
        wait_clk(4);
    endtask

    task automatic close_frame();
        wait_clk(4);
        bus.cs_n_i = 1'b1;
        bus.sclk_i = 1'b0;
        wait_clk(6);
    endtask

    task automatic send_byte(input logic [7:0] v, input logic expect_push);
        open_frame();
        send_bits(v, 8);
        close_frame();
        if (expect_push) exp_q.push_back(v);
    endtask

    task automatic pop_one();
        bus.rd_i = 1'b1;
        wait_clk(1);
        bus.rd_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rvalid"}, {31'h0, bus.rvalid_o}, 32'h0);
        check({tag, "_full"},   {31'h0, bus.full_o},   32'h0);
        check({tag, "_ovf"},    {31'h0, bus.ovf_o},    32'h0);
        check({tag, "_rdata"},  {24'h0, bus.rdata_o},  32'h0);
    endtask

    initial begin
        bus.sdata_i = 1'b0;
        bus.sclk_i  = 1'b0;
        bus.cs_n_i  = 1'b1;
        bus.rd_i    = 1'b0;
        wait_clk(3);
        check_reset_outputs("por");
        rst_n = 1'b1;
        wait_clk(3);

        // Reset in the middle of a frame: the 5 bits before and 3 after never make a word
        open_frame();
        send_bits(8'b10110_000, 5);
        bus.sclk_i = 1'b0;
        wait_clk(4);
        rst_n = 1'b0;
        wait_clk(2);
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        wait_clk(2);
        send_bits(8'b111_00000, 3);
        close_frame();
        check("midrst_nopush", {31'h0, bus.rvalid_o}, 32'h0);

        // 0xA5 with latency check on the last strobe
        open_frame();
        send_bits(8'hA5, 7);
        bus.sdata_i = 1'b1;
        bus.sclk_i  = 1'b0;
        wait_clk(8);
        bus.sclk_i  = 1'b1;
        exp_q.push_back(8'hA5);
        wait_clk(1);
        check("lat_edge_k",  {31'h0, bus.rvalid_o}, 32'h0);
        wait_clk(1);
        check("lat_edge_k1", {31'h0, bus.rvalid_o}, 32'h0);
        wait_clk(1);
        check("lat_edge_k2", {31'h0, bus.rvalid_o}, 32'h1);
        check("lat_rdata",   {24'h0, bus.rdata_o},  32'hA5);
        wait_clk(5);
        close_frame();
        pop_one();
        check("a5_empty", {31'h0, bus.rvalid_o}, 32'h0);
        pop_one();
        check("empty_pop_rvalid", {31'h0, bus.rvalid_o}, 32'h0);
        check("empty_pop_ovf",    {31'h0, bus.ovf_o},    32'h0);

        // Four bytes in one frame fill the FIFO; a fifth is dropped
        open_frame();
        for (int i = 1; i <= 4; i++) begin
            send_bits(8'(i), 8);
            exp_q.push_back(8'(i));
        end
        close_frame();
        check("fill_full", {31'h0, bus.full_o}, 32'h1);
        check("fill_ovf",  {31'h0, bus.ovf_o},  32'h0);
        send_byte(8'hFF, 1'b0);
        check("drop_ovf",  {31'h0, bus.ovf_o},  32'h1);
        check("drop_full", {31'h0, bus.full_o}, 32'h1);
        pop_one();
        check("pop1_full", {31'h0, bus.full_o}, 32'h0);
        repeat (3) pop_one();
        check("drain_rvalid", {31'h0, bus.rvalid_o}, 32'h0);
        check("ovf_sticky",   {31'h0, bus.ovf_o},    32'h1);

        rst_n = 1'b0;
        wait_clk(2);
        check("rst_clears_ovf", {31'h0, bus.ovf_o}, 32'h0);
        rst_n = 1'b1;
        wait_clk(3);

        // Full FIFO with push and pop landing on the same edge
        open_frame();
        send_bits(8'h11, 8); exp_q.push_back(8'h11);
        send_bits(8'h22, 8); exp_q.push_back(8'h22);
        send_bits(8'h33, 8); exp_q.push_back(8'h33);
        send_bits(8'h44, 8); exp_q.push_back(8'h44);
        close_frame();
        check("pp_pre_full", {31'h0, bus.full_o}, 32'h1);
        open_frame();
        send_bits(8'h55, 7);
        bus.sdata_i = 1'b1;
        bus.sclk_i  = 1'b0;
        wait_clk(8);
        bus.sclk_i  = 1'b1;
        exp_q.push_back(8'h55);
        wait_clk(2);
        bus.rd_i = 1'b1;
        wait_clk(1);
        bus.rd_i = 1'b0;
        check("pp_full", {31'h0, bus.full_o}, 32'h1);
        check("pp_ovf",  {31'h0, bus.ovf_o},  32'h0);
        wait_clk(5);
        close_frame();
        repeat (4) pop_one();
        check("pp_drained", {31'h0, bus.rvalid_o}, 32'h0);

        // Aborted 5-bit frame, then a clean 0x3C
        open_frame();
        send_bits(8'b01101_000, 5);
        close_frame();
        check("abort_nopush", {31'h0, bus.rvalid_o}, 32'h0);
        send_byte(8'h3C, 1'b1);
        check("3c_rvalid", {31'h0, bus.rvalid_o}, 32'h1);
        check("3c_rdata",  {24'h0, bus.rdata_o},  32'h3C);
        pop_one();
        check("3c_empty", {31'h0, bus.rvalid_o}, 32'h0);

        // ena low mid-byte: no push, earlier data still poppable
        send_byte(8'h77, 1'b1);
        open_frame();
        send_bits(8'hC3, 3);
        ena = 1'b0;
        send_bits(8'hF8, 5);
        close_frame();
        check("ena_rvalid", {31'h0, bus.rvalid_o}, 32'h1);
        check("ena_rdata",  {24'h0, bus.rdata_o},  32'h77);
        pop_one();
        check("ena_pop_empty", {31'h0, bus.rvalid_o}, 32'h0);
        check("ena_ovf",       {31'h0, bus.ovf_o},    32'h0);
        ena = 1'b1;
        wait_clk(4);

        check("scoreboard_empty", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
